program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 uart_rx  input  1  serial data, 8N1, idle high, asynchronous to clk.
REQ-006 ram_mode  output  1  high while loader owns RAM programming.
REQ-007 ram_addr  output  4  RAM address for current write.
REQ-008 ram_data  output  8  RAM data for current write.
REQ-009 ram_we  output  1  single-cycle write strobe; ram_addr/ram_data valid in same cycle.
REQ-010 done  output  1  high after a complete, accepted image; cleared by next sync byte.
REQ-011 error  output  1  high after framing or checksum failure; cleared by next sync byte.

Function
REQ-012 uart_rx passes a 2-flop synchroniser before any use.
REQ-013 Receiver detects start bit on falling edge, re-samples at CLKS_PER_BIT/2; start still low -> samples 8 data bits LSB-first at CLKS_PER_BIT spacing, then stop bit.
REQ-014 Start low at mid-sample -> byte accepted; start high at mid-sample -> false start, discarded silently, no error, receiver back to idle.
REQ-015 Stop bit low -> framing error; byte discarded.
REQ-016 Received byte presented to FSM as 1-cycle rx_valid plus rx_byte, one cycle after stop-bit sample.
REQ-017 FSM states: IDLE, LOAD, CHECK, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR: rx_valid with byte 0xA5 -> LOAD; index cleared to 0, sum cleared to 0, done and error cleared, ram_mode set in same edge.
REQ-019 IDLE/DONE/ERROR: any other byte ignored; state unchanged.
REQ-020 LOAD: each rx_valid -> ram_addr=index, ram_data=byte, ram_we=1 for exactly next cycle; sum += byte mod 256; index += 1.
REQ-021 LOAD: 16th byte written (index 15) -> CHECK when checksum compiled in, else DONE; index wraps 15->0, never beyond.
REQ-022 Byte value 0xA5 inside LOAD is data, not resync.
REQ-023 CHECK: next byte == sum -> DONE; else -> ERROR; ram_we never asserted in CHECK.
REQ-024 Framing error in LOAD or CHECK -> ERROR; framing error in IDLE/DONE/ERROR ignored.
REQ-025 Entering DONE: done=1, ram_mode=0. Entering ERROR: error=1, ram_mode=0.
REQ-026 ram_mode high exactly in LOAD and CHECK; ram_addr/ram_data hold last written values outside writes.
REQ-027 Checksum failure does not roll back already-written RAM bytes.
REQ-028 done and error never both high.

Reset
REQ-029 rst_n low asynchronously forces: IDLE, receiver idle, synchroniser flops to 1, index=0, sum=0, ram_mode=0, ram_addr=0, ram_data=0, ram_we=0, done=0, error=0.
REQ-030 Reset mid-byte or mid-image abandons it; next load requires fresh 0xA5.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN defined: CHECK state and sum register present; image = 0xA5 + 16 data + 1 checksum.
REQ-032 LOADER_CHECKSUM_EN undefined: CHECK state and sum logic absent; image = 0xA5 + 16 data; LOAD -> DONE directly; error only from framing.

Structure
REQ-033 Shared package holds loader state enum, SYNC_BYTE (8'hA5), IMAGE_BYTES (16).
REQ-034 Sub-module uart_rx (synchroniser, bit timer, shifter, rx_valid/rx_byte/frame_err) instantiated once; FSM in program_loader.

Verification
REQ-035 Send 0xA5, bytes 0x00..0x0F, checksum 0x78 -> 16 ram_we pulses, addr k data k, then done=1, ram_mode=0.
REQ-036 Same image with checksum 0x77 (LOADER_CHECKSUM_EN) -> 16 writes, error=1, done=0.
REQ-037 Bytes 0x11, 0x22 before 0xA5 -> no ram_we, ram_mode stays 0 until 0xA5.
REQ-038 Stop bit forced low on 5th data byte -> 4 writes only, error=1, ram_mode=0; new 0xA5 clears error, reloads from addr 0.
REQ-039 rst_n low after 8th data byte -> all outputs 0 immediately; subsequent full image loads correctly.
REQ-040 0.25-bit low glitch on idle line -> no rx_valid, no state change.

Source files
------------

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the program loader
//
// Purpose : loader and receiver state encodings, sync byte and image size.
// Ports   : none (package).

package program_loader_pkg;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         IMAGE_BYTES = 16;
   localparam int         ADDR_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } loader_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   function automatic logic is_sync(input logic [7:0] b);
      return b == SYNC_BYTE;
   endfunction

endpackage

// File: rtl/program_loader_uart_rx.sv
// rtl/program_loader_uart_rx.sv - 8N1 UART receiver with input synchroniser
//
// Purpose : synchronises the serial line, finds start bits on falling edges,
//           samples mid-bit and reports each received byte or framing error.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           rx             - raw serial input, idle high
//           rx_valid       - 1-cycle pulse, rx_byte holds a good byte
//           rx_byte        - last good byte, LSB received first
//           frame_err      - 1-cycle pulse, stop bit sampled low

module uart_rx
   import program_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 234
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CW       = $clog2(CLKS_PER_BIT + 1);

   logic            sync1;
   logic            sync2;
   logic            rx_prev;
   rx_state_t       st;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         rx_prev   <= 1'b1;
         st        <= RX_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_valid  <= 1'b0;
         rx_byte   <= '0;
         frame_err <= 1'b0;
      end else begin
         sync1     <= rx;
         sync2     <= sync1;
         rx_prev   <= sync2;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (st)
            RX_IDLE: begin
               // Only a high-to-low transition starts a byte, so a line held
               // low after a broken stop bit cannot retrigger the receiver.
               if (rx_prev && !sync2) begin
                  st  <= RX_START;
                  cnt <= '0;
               end
            end
            RX_START: begin
               if (cnt == CW'(HALF_BIT - 1)) begin
                  cnt <= '0;
                  if (!sync2) begin
                     st      <= RX_DATA;
                     bit_idx <= '0;
                  end else begin
                     // Short glitch: line already back high at mid start bit.
                     st <= RX_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                  cnt   <= '0;
                  shreg <= {sync2, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     st <= RX_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                  cnt <= '0;
                  st  <= RX_IDLE;
                  if (sync2) begin
                     rx_valid <= 1'b1;
                     rx_byte  <= shreg;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: st <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART-fed loader writing a 16-byte image into RAM
//
// Purpose : waits for sync byte 0xA5, writes the following 16 bytes to RAM
//           addresses 0..15, then reports done or error.
// Config  : LOADER_CHECKSUM_EN - adds a trailing mod-256 checksum byte that
//           must match the sum of the 16 data bytes.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           uart_rx        - serial input, 8N1, idle high
//           ram_mode       - high while the loader owns the RAM
//           ram_addr       - RAM write address (holds last written value)
//           ram_data       - RAM write data (holds last written value)
//           ram_we         - single-cycle RAM write strobe
//           done           - image accepted, cleared by next sync byte
//           error          - framing/checksum failure, cleared by next sync

module program_loader
   import program_loader_pkg::*;
#(
   parameter int CLK_HZ = 27000000,
   parameter int BAUD   = 115200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              uart_rx,
   output logic              ram_mode,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_data,
   output logic              ram_we,
   output logic              done,
   output logic              error
);

   localparam int                CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam logic [ADDR_W-1:0] LAST_INDEX   = ADDR_W'(IMAGE_BYTES - 1);

   logic              rx_valid;
   logic [7:0]        rx_byte;
   logic              frame_err;
   loader_state_t     state;
   logic [ADDR_W-1:0] index;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        sum;
`endif

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (uart_rx),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .frame_err (frame_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         index    <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum      <= '0;
`endif
         ram_mode <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
         ram_we   <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               // Framing errors and non-sync bytes are ignored here.
               if (rx_valid && is_sync(rx_byte)) begin
                  state    <= ST_LOAD;
                  index    <= '0;
`ifdef LOADER_CHECKSUM_EN
                  sum      <= '0;
`endif
                  done     <= 1'b0;
                  error    <= 1'b0;
                  ram_mode <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (frame_err) begin
                  state    <= ST_ERROR;
                  error    <= 1'b1;
                  ram_mode <= 1'b0;
               end else if (rx_valid) begin
                  // Every byte is data here, including 0xA5.
                  ram_we   <= 1'b1;
                  ram_addr <= index;
                  ram_data <= rx_byte;
                  index    <= index + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  sum      <= sum + rx_byte;
`endif
                  if (index == LAST_INDEX) begin
`ifdef LOADER_CHECKSUM_EN
                     state    <= ST_CHECK;
`else
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     ram_mode <= 1'b0;
`endif
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
               // Written bytes stay in RAM even if the checksum fails.
               if (frame_err) begin
                  state    <= ST_ERROR;
                  error    <= 1'b1;
                  ram_mode <= 1'b0;
               end else if (rx_valid) begin
                  ram_mode <= 1'b0;
                  if (rx_byte == sum) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader

module tb_program_loader;
   import program_loader_pkg::*;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_rx = 1'b1;
   logic       ram_mode;
   logic [3:0] ram_addr;
   logic [7:0] ram_data;
   logic       ram_we;
   logic       done;
   logic       error;

   int n_tests = 0;
   int n_fail  = 0;
   logic prev_we = 1'b0;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;
   wr_t exp_q[$];

   typedef struct {
      logic [7:0] first;
      logic [7:0] step;
      logic [7:0] cks_delta;
      logic       exp_done;
      logic       exp_error;
   } vec_t;
   vec_t vecs[$];

   logic [7:0] last_byte;

   program_loader #(.CLK_HZ(1600), .BAUD(100)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .uart_rx  (uart_rx),
      .ram_mode (ram_mode),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .ram_we   (ram_we),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every ram_we pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (ram_we) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, required no write", ram_addr, ram_data);
         end else begin
            check("wr_addr", ram_addr, exp_q[0].addr);
            check("wr_data", ram_data, exp_q[0].data);
            void'(exp_q.pop_front());
         end
         if (prev_we) begin
            n_tests++;
            n_fail++;
            $display("FAIL we_width: ram_we high 2 cycles, required 1");
         end
      end
      if (done && error) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_and_error: both 1, required at most one");
      end
      prev_we <= ram_we;
   end

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = bad_stop ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_data(input logic [3:0] k, input logic [7:0] d);
      exp_q.push_back('{addr: k, data: d});
      send_byte(d, 1'b0);
   endtask

   task automatic send_image(input logic [7:0] first, input logic [7:0] step,
                             input logic [7:0] cks_delta);
      logic [7:0] d;
      logic [7:0] s;
      s = 8'h00;
      send_byte(SYNC_BYTE, 1'b0);
      check("ram_mode_after_sync", ram_mode, 1);
      for (int k = 0; k < 16; k++) begin
         d = first + 8'(step * k);
         s = s + d;
         send_data(4'(k), d);
      end
      last_byte = d;
`ifdef LOADER_CHECKSUM_EN
      send_byte(s + cks_delta, 1'b0);
`else
      s = s + cks_delta;
`endif
      repeat (4) @(negedge clk);
      check("writes_outstanding", exp_q.size(), 0);
   endtask

   initial begin
      vecs.push_back('{first: 8'h00, step: 8'h01, cks_delta: 8'h00, exp_done: 1'b1, exp_error: 1'b0});
      vecs.push_back('{first: 8'hA5, step: 8'h00, cks_delta: 8'h00, exp_done: 1'b1, exp_error: 1'b0});
      vecs.push_back('{first: 8'hF0, step: 8'h13, cks_delta: 8'h00, exp_done: 1'b1, exp_error: 1'b0});
`ifdef LOADER_CHECKSUM_EN
      // checksum 0x78 + 0xFF = 0x77: wrong by one
      vecs.push_back('{first: 8'h00, step: 8'h01, cks_delta: 8'hFF, exp_done: 1'b0, exp_error: 1'b1});
`endif

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ram_mode", ram_mode, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_data", ram_data, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Noise before sync is ignored
      send_byte(8'h11, 1'b0);
      check("noise1_ram_mode", ram_mode, 0);
      send_byte(8'h22, 1'b0);
      check("noise2_ram_mode", ram_mode, 0);
      check("noise2_done", done, 0);

      // Table-driven images
      for (int v = 0; v < vecs.size(); v++) begin
         send_image(vecs[v].first, vecs[v].step, vecs[v].cks_delta);
         check("img_done", done, vecs[v].exp_done);
         check("img_error", error, vecs[v].exp_error);
         check("img_ram_mode", ram_mode, 0);
         check("img_ram_addr_hold", ram_addr, 4'hF);
         check("img_ram_data_hold", ram_data, last_byte);
      end

      // Quarter-bit glitch on idle line
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch_done", done, vecs[vecs.size()-1].exp_done);
      check("glitch_error", error, vecs[vecs.size()-1].exp_error);
      check("glitch_ram_mode", ram_mode, 0);

      // Framing error outside LOAD/CHECK is ignored
      send_byte(8'h5A, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      check("idle_ferr_done", done, vecs[vecs.size()-1].exp_done);
      check("idle_ferr_error", error, vecs[vecs.size()-1].exp_error);

      // Framing error on 5th data byte
      send_byte(SYNC_BYTE, 1'b0);
      check("ferr_sync_done", done, 0);
      check("ferr_sync_error", error, 0);
      for (int k = 0; k < 4; k++) send_data(4'(k), 8'h30 + 8'(k));
      send_byte(8'h34, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      check("ferr_error", error, 1);
      check("ferr_done", done, 0);
      check("ferr_ram_mode", ram_mode, 0);
      check("ferr_ram_addr", ram_addr, 4'h3);
      check("ferr_ram_data", ram_data, 8'h33);
      check("ferr_writes", exp_q.size(), 0);
      send_image(8'h40, 8'h01, 8'h00);
      check("reload_done", done, 1);
      check("reload_error", error, 0);

      // Reset mid-image after 8 data bytes
      send_byte(SYNC_BYTE, 1'b0);
      for (int k = 0; k < 8; k++) send_data(4'(k), 8'hC0 ^ 8'(k));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ram_mode", ram_mode, 0);
      check("midrst_ram_addr", ram_addr, 0);
      check("midrst_ram_data", ram_data, 0);
      check("midrst_ram_we", ram_we, 0);
      check("midrst_done", done, 0);
      check("midrst_error", error, 0);
      check("midrst_writes", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      send_image(8'h00, 8'h01, 8'h00);
      check("post_rst_done", done, 1);
      check("post_rst_error", error, 0);
      check("post_rst_ram_mode", ram_mode, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
